// File: rtl/hms_clock.sv
// Hours/minutes/seconds clock with set controls, 12/24-hour display and a
// multiplexed 6-digit seven-segment driver (active-low C, DP, AN).
`timescale 1ns/1ps
module hms_clock #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 41_667
) (
    input  logic       CLK100MHZ,
    input  logic       R,
    input  logic       run,
    input  logic       mode12,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       clr_sec,
    output logic [6:0] C,
    output logic       DP,
    output logic [7:0] AN,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
    localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [2:0]    digit_q, digit_d;
    logic [4:0]    hr_q, hr_d;
    logic [5:0]    min_q, min_d, sec_q, sec_d;
    logic          tick_q, tick_d, dp_q, dp_d;
    logic [6:0]    c_q, c_d;
    logic [7:0]    an_q, an_d;
    logic [4:0]    disp_hr;
    logic [3:0]    digit_val;

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if (v >= 6'd50)      return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        logic [5:0] r;
        r = v - 6'(tens_of(v)) * 6'd10;
        return r[3:0];
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Timekeeping: prescaler-driven carry chain while running, set pulses while held
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        if (run) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d = 6'd0;
                        hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            if (inc_hr)  hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            if (inc_min) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            if (clr_sec) begin
                sec_d   = 6'd0;
                presc_d = '0;
            end
        end
    end

    // Display: free-running scan and registered segment/anode outputs
    always_comb begin
        scan_d  = (scan_q == SCAN_MAX) ? '0 : scan_q + SW'(1);
        digit_d = digit_q;
        if (scan_q == SCAN_MAX) digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;

        if (!mode12)            disp_hr = hr_q;
        else if (hr_q == 5'd0)  disp_hr = 5'd12;
        else if (hr_q > 5'd12)  disp_hr = hr_q - 5'd12;
        else                    disp_hr = hr_q;

        case (digit_q)
            3'd0:    digit_val = ones_of(sec_q);
            3'd1:    digit_val = tens_of(sec_q);
            3'd2:    digit_val = ones_of(min_q);
            3'd3:    digit_val = tens_of(min_q);
            3'd4:    digit_val = ones_of({1'b0, disp_hr});
            default: digit_val = tens_of({1'b0, disp_hr});
        endcase

        c_d = seg7(digit_val);
        if (digit_q == 3'd5 && mode12 && digit_val == 4'd0) c_d = 7'b1111111;

        an_d          = 8'hFF;
        an_d[digit_q] = 1'b0;

        dp_d = 1'b1;
        if ((digit_q == 3'd2 || digit_q == 3'd4) && presc_q < PRESC_HALF) dp_d = 1'b0;
        if (digit_q == 3'd0 && mode12 && hr_q >= 5'd12) dp_d = 1'b0;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (R) begin
            presc_q <= '0;
            scan_q  <= '0;
            digit_q <= 3'd0;
            hr_q    <= 5'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            tick_q  <= 1'b0;
            c_q     <= 7'b1111111;
            dp_q    <= 1'b1;
            an_q    <= 8'hFF;
        end else begin
            presc_q <= presc_d;
            scan_q  <= scan_d;
            digit_q <= digit_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            c_q     <= c_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign C       = c_q;
    assign DP      = dp_q;
    assign AN      = an_q;
    assign hours   = hr_q;
    assign minutes = min_q;
    assign seconds = sec_q;
    assign tick    = tick_q;
endmodule

// File: tb/tb_hms_clock.sv
// Directed bench for hms_clock with a 10-cycle second and 4-cycle digit slot.
`timescale 1ns/1ps
module tb_hms_clock;
    localparam int TD = 10;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       R = 1'b1, run = 1'b0, mode12 = 1'b0;
    logic       inc_hr = 1'b0, inc_min = 1'b0, clr_sec = 1'b0;
    logic [6:0] C;
    logic       DP;
    logic [7:0] AN;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic       tick;

    int checks = 0;
    int errors = 0;

    hms_clock #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .CLK100MHZ(clk), .R(R), .run(run), .mode12(mode12),
        .inc_hr(inc_hr), .inc_min(inc_min), .clr_sec(clr_sec),
        .C(C), .DP(DP), .AN(AN),
        .hours(hours), .minutes(minutes), .seconds(seconds), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, "_hr"}, 32'(hours), 32'(h));
        chk({tag, "_min"}, 32'(minutes), 32'(m));
        chk({tag, "_sec"}, 32'(seconds), 32'(s));
    endtask

    task automatic pulse_hr(input int n);
        for (int i = 0; i < n; i++) begin
            inc_hr = 1'b1; step(); inc_hr = 1'b0;
        end
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            inc_min = 1'b1; step(); inc_min = 1'b0;
        end
    endtask

    task automatic wait_ticks(input int n);
        int cnt = 0;
        int cyc = 0;
        while (cnt < n && cyc < n * TD + 20) begin
            step();
            cyc++;
            if (tick) cnt++;
        end
        chk("tick_count", 32'(cnt), 32'(n));
    endtask

    // Step until AN selects digit d, then report that slot's C and DP.
    task automatic capture(input int d, output logic [6:0] c_o, output logic dp_o);
        logic [7:0] want;
        int g = 0;
        want = ~(8'h01 << d);
        do begin
            step();
            g++;
        end while (AN !== want && g < 40);
        chk("scan_find", 32'(AN), 32'(want));
        c_o  = C;
        dp_o = DP;
    endtask

    logic [6:0] c_s;
    logic       dp_s;
    logic [7:0] an_seq [6];
    int ticks, cyc, last;

    initial begin
        an_seq[0] = 8'hFE; an_seq[1] = 8'hFD; an_seq[2] = 8'hFB;
        an_seq[3] = 8'hF7; an_seq[4] = 8'hEF; an_seq[5] = 8'hDF;

        // Reset values
        step(); step();
        chk_time("rst", 0, 0, 0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_C", 32'(C), 32'h7F);
        chk("rst_DP", 32'(DP), 32'd1);
        chk("rst_AN", 32'(AN), 32'hFF);

        // 600 ticks, each exactly TD cycles apart (first one TD after release)
        R = 1'b0; run = 1'b1;
        ticks = 0; cyc = 0; last = 0;
        while (ticks < 600 && cyc < 7000) begin
            step();
            cyc++;
            if (tick) begin
                chk("tick_gap", 32'(cyc - last), 32'(TD));
                last = cyc;
                ticks++;
            end
        end
        run = 1'b0;
        chk("ticks_600", 32'(ticks), 32'd600);
        chk_time("t600", 0, 10, 0);

        // Simultaneous set pulses, then preset to 23:59:58
        inc_hr = 1'b1; inc_min = 1'b1; clr_sec = 1'b1;
        step();
        inc_hr = 1'b0; inc_min = 1'b0; clr_sec = 1'b0;
        chk_time("simul", 1, 11, 0);
        pulse_hr(22);
        pulse_min(48);
        chk_time("preset", 23, 59, 0);
        run = 1'b1; wait_ticks(58); run = 1'b0;
        chk_time("pre58", 23, 59, 58);
        run = 1'b1; wait_ticks(1);
        chk_time("t59", 23, 59, 59);
        wait_ticks(1); run = 1'b0;
        chk_time("wrap", 0, 0, 0);

        // inc_min wraps without carrying into hours
        pulse_hr(5);
        pulse_min(61);
        chk_time("min61", 5, 1, 0);

        // Set pulses ignored while running
        run = 1'b1; inc_hr = 1'b1; inc_min = 1'b1;
        step();
        inc_hr = 1'b0; inc_min = 1'b0;
        step();
        chk_time("ign_run", 5, 1, 0);
        chk("ign_tick", 32'(tick), 32'd0);
        run = 1'b0; clr_sec = 1'b1; step(); clr_sec = 1'b0;

        // 12-hour display at hours 0 -> "12"
        pulse_hr(19);
        chk("hr0", 32'(hours), 32'd0);
        mode12 = 1'b1;
        capture(4, c_s, dp_s); chk("h0m12_ones", 32'(c_s), 32'h12);
        capture(5, c_s, dp_s); chk("h0m12_tens", 32'(c_s), 32'h4F);
        capture(0, c_s, dp_s); chk("h0m12_pm", 32'(dp_s), 32'd1);
        mode12 = 1'b0;
        capture(5, c_s, dp_s); chk("h0m24_tens", 32'(c_s), 32'h01);

        // Hours 13: "1" with blank tens and PM dot in 12-hour mode
        pulse_hr(13);
        mode12 = 1'b1;
        capture(4, c_s, dp_s); chk("h13m12_ones", 32'(c_s), 32'h4F);
        capture(5, c_s, dp_s); chk("h13m12_blank", 32'(c_s), 32'h7F);
        capture(0, c_s, dp_s); chk("h13m12_pm", 32'(dp_s), 32'd0);
        capture(2, c_s, dp_s); chk("min_ones", 32'(c_s), 32'h4F);
        chk("colon_dp", 32'(dp_s), 32'd0);
        capture(3, c_s, dp_s); chk("min_tens", 32'(c_s), 32'h01);
        chk("min_tens_dp", 32'(dp_s), 32'd1);
        mode12 = 1'b0;
        capture(4, c_s, dp_s); chk("h13m24_ones", 32'(c_s), 32'h06);
        capture(0, c_s, dp_s); chk("h13m24_pm", 32'(dp_s), 32'd1);

        // Anode scan sequence, each digit held SD cycles
        cyc = 0;
        while (AN !== 8'hDF && cyc < 40) begin step(); cyc++; end
        while (AN !== 8'hFE && cyc < 80) begin step(); cyc++; end
        chk("scan_align", 32'(AN), 32'hFE);
        for (int i = 0; i < 48; i++) begin
            chk("scan_an", 32'(AN), 32'(an_seq[(i / SD) % 6]));
            step();
        end

        // Reach 12:34:56, run mid-second, then reset
        pulse_hr(23);
        pulse_min(33);
        clr_sec = 1'b1; step(); clr_sec = 1'b0;
        run = 1'b1; wait_ticks(56);
        step(); step(); step();
        chk_time("pre_rst", 12, 34, 56);
        R = 1'b1; inc_hr = 1'b1; inc_min = 1'b1;
        step();
        chk_time("mid_rst", 0, 0, 0);
        chk("mid_rst_tick", 32'(tick), 32'd0);
        chk("mid_rst_C", 32'(C), 32'h7F);
        chk("mid_rst_DP", 32'(DP), 32'd1);
        chk("mid_rst_AN", 32'(AN), 32'hFF);
        R = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
        cyc = 0;
        do begin step(); cyc++; end while (!tick && cyc < 30);
        chk("first_tick_lat", 32'(cyc), 32'(TD));
        chk_time("restart", 0, 0, 1);
        run = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
